// File: rtl/toffoli_cascade_engine.sv
// Time-multiplexed Toffoli cascade: applies a programmable gate table to a word,
// one gate per clock, forward or reverse, with valid/ready handshakes on both sides.
module toffoli_cascade_engine #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we,
    input  logic [$clog2(DEPTH)-1:0]    cfg_addr,
    input  logic [$clog2(WIDTH)-1:0]    cfg_c1,
    input  logic [$clog2(WIDTH)-1:0]    cfg_c2,
    input  logic [$clog2(WIDTH)-1:0]    cfg_t,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    input  logic [$clog2(DEPTH):0]      in_count,
    input  logic                        in_dir,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_err
);
    localparam int IDXW  = $clog2(WIDTH);
    localparam int ADDRW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ADDRW:0] DEPTH_N = (ADDRW + 1)'(DEPTH);
    localparam logic [IDXW:0]  WIDTH_N = (IDXW + 1)'(WIDTH);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_word;
    logic             r_err;
    logic             r_dir;
    logic [ADDRW-1:0] r_ptr;
    logic [ADDRW:0]   r_rem;

    logic [DEPTH-1:0] r_tv;
    logic [IDXW-1:0]  r_tc1 [DEPTH];
    logic [IDXW-1:0]  r_tc2 [DEPTH];
    logic [IDXW-1:0]  r_tt  [DEPTH];

    logic [ADDRW:0]   w_n;
    logic [ADDRW:0]   w_nm1;
    logic             w_valid;
    logic             w_legal;
    logic [IDXW-1:0]  w_c1;
    logic [IDXW-1:0]  w_c2;
    logic [IDXW-1:0]  w_t;
    logic [WIDTH-1:0] w_word_next;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_data  = r_word;
    assign out_err   = r_err;

    assign w_n   = (in_count > DEPTH_N) ? DEPTH_N : in_count;
    assign w_nm1 = w_n - 1'b1;

    assign w_valid = r_tv[r_ptr];
    assign w_c1    = r_tc1[r_ptr];
    assign w_c2    = r_tc2[r_ptr];
    assign w_t     = r_tt[r_ptr];
    assign w_legal = ({1'b0, w_c1} < WIDTH_N) && ({1'b0, w_c2} < WIDTH_N) &&
                     ({1'b0, w_t} < WIDTH_N) && (w_c1 != w_t) && (w_c2 != w_t);

    // Illegal or unprogrammed entries leave the word untouched.
    always_comb begin
        w_word_next = r_word;
        if (w_valid && w_legal) begin
            w_word_next[w_t] = r_word[w_t] ^ (r_word[w_c1] & r_word[w_c2]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tv <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_tc1[i] <= '0;
                r_tc2[i] <= '0;
                r_tt[i]  <= '0;
            end
        end else if (cfg_we && (r_state == S_IDLE)) begin
            r_tv[cfg_addr]  <= 1'b1;
            r_tc1[cfg_addr] <= cfg_c1;
            r_tc2[cfg_addr] <= cfg_c2;
            r_tt[cfg_addr]  <= cfg_t;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_word  <= '0;
            r_err   <= 1'b0;
            r_dir   <= 1'b0;
            r_ptr   <= '0;
            r_rem   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_word  <= in_data;
                        r_dir   <= in_dir;
                        r_err   <= 1'b0;
                        r_rem   <= w_n;
                        r_ptr   <= in_dir ? w_nm1[ADDRW-1:0] : '0;
                        r_state <= (w_n == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    r_word <= w_word_next;
                    if (w_valid && !w_legal) begin
                        r_err <= 1'b1;
                    end
                    r_rem <= r_rem - 1'b1;
                    // Pointer holds on the last gate so it never wraps.
                    if (r_rem == 1) begin
                        r_state <= S_DONE;
                    end else begin
                        r_ptr <= r_dir ? (r_ptr - 1'b1) : (r_ptr + 1'b1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_toffoli_cascade_engine.sv
// Scoreboard bench for toffoli_cascade_engine: expected words come from a small
// cascade model of the table contents the bench has programmed.
module tb_toffoli_cascade_engine;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [2:0] cfg_c1 = '0;
    logic [2:0] cfg_c2 = '0;
    logic [2:0] cfg_t = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [4:0] in_count = '0;
    logic       in_dir = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_err;

    always #5 clk = ~clk;

    toffoli_cascade_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_c1    (cfg_c1),
        .cfg_c2    (cfg_c2),
        .cfg_t     (cfg_t),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_count  (in_count),
        .in_dir    (in_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] d;
        logic       e;
        int         lat;
    } exp_t;
    exp_t sb[$];

    logic       m_v  [DEPTH];
    logic [2:0] m_c1 [DEPTH];
    logic [2:0] m_c2 [DEPTH];
    logic [2:0] m_t  [DEPTH];

    function automatic void model(input logic [7:0] din, input int count, input logic dir,
                                  output logic [7:0] dout, output logic err);
        int n;
        int idx;
        dout = din;
        err  = 1'b0;
        n    = (count > DEPTH) ? DEPTH : count;
        for (int k = 0; k < n; k++) begin
            idx = dir ? (n - 1 - k) : k;
            if (m_v[idx]) begin
                if (m_c1[idx] == m_t[idx] || m_c2[idx] == m_t[idx]) err = 1'b1;
                else dout[m_t[idx]] = dout[m_t[idx]] ^ (dout[m_c1[idx]] & dout[m_c2[idx]]);
            end
        end
    endfunction

    task automatic push_exp(input logic [7:0] din, input int count, input logic dir);
        exp_t e;
        int   n;
        model(din, count, dir, e.d, e.e);
        n = (count > DEPTH) ? DEPTH : count;
        e.lat = (n == 0) ? 1 : n + 1;
        sb.push_back(e);
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [2:0] c1, input logic [2:0] c2,
                             input logic [2:0] t);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_c1 = c1; cfg_c2 = c2; cfg_t = t;
        @(posedge clk);
        #1 cfg_we = 1'b0;
        m_v[a] = 1'b1; m_c1[a] = c1; m_c2[a] = c2; m_t[a] = t;
    endtask

    // Drives one job, returns the first observed result, its latency in cycles after
    // the accept cycle, and whether the result held steady for 'hold' stalled cycles.
    task automatic run_job(input logic [7:0] din, input logic [4:0] cnt, input logic dir,
                           input int hold, input bit cfg_pulse, output logic [7:0] got_d,
                           output logic got_e, output int lat, output bit stable);
        int w;
        got_d = 'x; got_e = 'x; lat = -1; stable = 1'b0;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) return;
        in_valid = 1'b1; in_data = din; in_count = cnt; in_dir = dir;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_data = 8'($urandom); in_count = 5'($urandom); in_dir = ~dir;
        for (int c = 1; c <= 100; c++) begin
            cfg_we = (cfg_pulse && c == 2);
            if (cfg_we) begin
                cfg_addr = 4'd0; cfg_c1 = 3'd4; cfg_c2 = 3'd5; cfg_t = 3'd6;
            end
            @(negedge clk);
            if (out_valid) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        cfg_we = 1'b0;
        if (lat < 0) return;
        got_d  = out_data;
        got_e  = out_err;
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (out_data !== got_d || out_err !== got_e || in_ready !== 1'b0 ||
                out_valid !== 1'b1) stable = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready: got %b want 1", in_ready); n_bad++; end
        n_vec++; if (out_valid !== 1'b0) begin
            $display("FAIL reset_out_valid: got %b want 0", out_valid); n_bad++; end
        n_vec++; if (out_data !== 8'h00) begin
            $display("FAIL reset_out_data: got %h want 00", out_data); n_bad++; end
        n_vec++; if (out_err !== 1'b0) begin
            $display("FAIL reset_out_err: got %b want 0", out_err); n_bad++; end
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
    endtask

    task automatic test_single_gate();
        logic [7:0] d; logic e; int lat; bit st; exp_t x;
        cfg_write(4'd0, 3'd0, 3'd1, 3'd2);
        sb.push_back('{d: 8'h07, e: 1'b0, lat: 2});
        run_job(8'h03, 5'd1, 1'b0, 0, 1'b0, d, e, lat, st);
        x = sb.pop_front();
        n_vec++; if (d !== x.d) begin
            $display("FAIL single_data: got %h want %h", d, x.d); n_bad++; end
        n_vec++; if (e !== x.e) begin
            $display("FAIL single_err: got %b want %b", e, x.e); n_bad++; end
        n_vec++; if (lat != x.lat) begin
            $display("FAIL single_latency: got %0d want %0d", lat, x.lat); n_bad++; end
    endtask

    task automatic test_round_trip();
        logic [7:0] ins [3] = '{8'h03, 8'h8F, 8'h00};
        logic [7:0] exs [3] = '{8'h8F, 8'h03, 8'h00};
        logic       dirs [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] d; logic e; int lat; bit st; exp_t x;
        cfg_write(4'd1, 3'd2, 3'd2, 3'd3);
        cfg_write(4'd2, 3'd3, 3'd0, 3'd7);
        for (int j = 0; j < 3; j++) begin
            sb.push_back('{d: exs[j], e: 1'b0, lat: 4});
            run_job(ins[j], 5'd3, dirs[j], 0, 1'b0, d, e, lat, st);
            x = sb.pop_front();
            n_vec++; if (d !== x.d || e !== x.e) begin
                $display("FAIL round_trip_%0d: got %h/%b want %h/%b", j, d, e, x.d, x.e);
                n_bad++; end
            n_vec++; if (lat != x.lat) begin
                $display("FAIL round_trip_lat_%0d: got %0d want %0d", j, lat, x.lat);
                n_bad++; end
        end
    endtask

    task automatic test_count_bounds();
        logic [7:0] d; logic e; int lat; bit st; exp_t x;
        logic [2:0] t;
        for (int a = 3; a < DEPTH; a++) begin
            t = 3'($urandom_range(7));
            cfg_write(4'(a), 3'(t + 3'($urandom_range(6)) + 3'd1),
                      3'(t + 3'($urandom_range(6)) + 3'd1), t);
        end
        sb.push_back('{d: 8'hA5, e: 1'b0, lat: 1});
        run_job(8'hA5, 5'd0, 1'b0, 0, 1'b0, d, e, lat, st);
        x = sb.pop_front();
        n_vec++; if (d !== x.d || lat != x.lat) begin
            $display("FAIL count0: got %h lat %0d want %h lat %0d", d, lat, x.d, x.lat);
            n_bad++; end
        for (int j = 0; j < 2; j++) begin
            push_exp(8'h3C + 8'(j * 8'h41), 20, 1'(j));
            run_job(8'h3C + 8'(j * 8'h41), 5'd20, 1'(j), 0, 1'b0, d, e, lat, st);
            x = sb.pop_front();
            n_vec++; if (d !== x.d || e !== x.e) begin
                $display("FAIL count20_%0d: got %h/%b want %h/%b", j, d, e, x.d, x.e);
                n_bad++; end
            n_vec++; if (lat != x.lat) begin
                $display("FAIL count20_lat_%0d: got %0d want %0d", j, lat, x.lat); n_bad++; end
        end
    endtask

    task automatic test_illegal();
        logic [7:0] d; logic e; int lat; bit st; exp_t x;
        cfg_write(4'd0, 3'd2, 3'd1, 3'd2);
        sb.push_back('{d: 8'hFF, e: 1'b1, lat: 2});
        run_job(8'hFF, 5'd1, 1'b0, 0, 1'b0, d, e, lat, st);
        x = sb.pop_front();
        n_vec++; if (d !== x.d || e !== x.e) begin
            $display("FAIL illegal: got %h/%b want %h/%b", d, e, x.d, x.e); n_bad++; end
        cfg_write(4'd0, 3'd0, 3'd1, 3'd2);
        sb.push_back('{d: 8'h07, e: 1'b0, lat: 2});
        run_job(8'h03, 5'd1, 1'b0, 0, 1'b0, d, e, lat, st);
        x = sb.pop_front();
        n_vec++; if (d !== x.d || e !== x.e) begin
            $display("FAIL illegal_clear: got %h/%b want %h/%b", d, e, x.d, x.e); n_bad++; end
    endtask

    task automatic test_backpressure();
        logic [7:0] d; logic e; int lat; bit st; exp_t x;
        sb.push_back('{d: 8'h8F, e: 1'b0, lat: 4});
        run_job(8'h03, 5'd3, 1'b0, 5, 1'b0, d, e, lat, st);
        x = sb.pop_front();
        n_vec++; if (d !== x.d || e !== x.e) begin
            $display("FAIL bp_data: got %h/%b want %h/%b", d, e, x.d, x.e); n_bad++; end
        n_vec++; if (st !== 1'b1) begin
            $display("FAIL bp_stable: got %b want 1", st); n_bad++; end
    endtask

    task automatic test_cfg_lockout();
        logic [7:0] d; logic e; int lat; bit st; exp_t x;
        for (int r = 0; r < 2; r++) begin
            push_exp(8'h03, 10, 1'b0);
            run_job(8'h03, 5'd10, 1'b0, 0, (r == 0), d, e, lat, st);
            x = sb.pop_front();
            n_vec++; if (d !== x.d || e !== x.e) begin
                $display("FAIL lockout_%0d: got %h/%b want %h/%b", r, d, e, x.d, x.e);
                n_bad++; end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] d; logic e; int lat; bit st; exp_t x;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h03; in_count = 5'd10; in_dir = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL midrun_reset: got valid %b ready %b want 0 1", out_valid, in_ready);
            n_bad++; end
        n_vec++; if (out_data !== 8'h00 || out_err !== 1'b0) begin
            $display("FAIL midrun_reset_out: got %h/%b want 00/0", out_data, out_err);
            n_bad++; end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
        push_exp(8'h5A, 10, 1'b0);
        run_job(8'h5A, 5'd10, 1'b0, 0, 1'b0, d, e, lat, st);
        x = sb.pop_front();
        n_vec++; if (d !== 8'h5A || d !== x.d || e !== x.e || lat != x.lat) begin
            $display("FAIL after_reset: got %h/%b lat %0d want %h/%b lat %0d",
                     d, e, lat, x.d, x.e, x.lat);
            n_bad++; end
    endtask

    initial begin
        test_reset();
        test_single_gate();
        test_round_trip();
        test_count_bounds();
        test_illegal();
        test_backpressure();
        test_cfg_lockout();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
